// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: steps {A,B,C} through every code, samples dut_out after a settle window and checks it against EXP_TABLE.
// Optional STOP_ON_FAIL_EN ends the sweep at the first mismatching code.
module truth_table_sweeper #(
  parameter int N_IN = 3,
  parameter logic [2**N_IN-1:0] EXP_TABLE = 8'b10010110,
  parameter int SETTLE_CYC = 2
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic                 i_dut_out,
  output logic [N_IN-1:0]      o_sel_abc,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_pass,
  output logic [N_IN:0]        o_err_count,
  output logic [N_IN-1:0]      o_fail_idx,
  output logic [2**N_IN-1:0]   o_captured
);
  localparam logic [N_IN-1:0] LAST = N_IN'(2**N_IN - 1);
  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;
  state_t r_state, w_next;
  logic [7:0] r_cnt;
  logic [N_IN-1:0] r_sel, r_fail;
  logic [N_IN:0] r_err;
  logic [2**N_IN-1:0] r_cap;
  logic w_mis, w_last;
  assign w_mis = i_dut_out != EXP_TABLE[r_sel];
`ifdef STOP_ON_FAIL_EN
  assign w_last = (r_sel == LAST) | w_mis;
`else
  assign w_last = r_sel == LAST;
`endif
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE: w_next = i_start ? SETTLE : r_state;
      SETTLE:     w_next = (r_cnt == 8'(SETTLE_CYC - 1)) ? SAMPLE : SETTLE;
      SAMPLE:     w_next = w_last ? DONE : SETTLE;
      default:    w_next = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_sel   <= '0;
      r_fail  <= '0;
      r_err   <= '0;
      r_cap   <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE, DONE: if (i_start) begin
          r_cnt  <= '0;
          r_sel  <= '0;
          r_fail <= '0;
          r_err  <= '0;
          r_cap  <= '0;
        end
        SETTLE: r_cnt <= r_cnt + 8'd1;
        SAMPLE: begin
          r_cap[r_sel] <= i_dut_out;
          if (w_mis) begin
            r_err <= r_err + 1'b1;
            if (r_err == '0) r_fail <= r_sel;
          end
          if (!w_last) begin
            r_sel <= r_sel + 1'b1;
            r_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end
  assign o_sel_abc   = r_sel;
  assign o_busy      = (r_state == SETTLE) | (r_state == SAMPLE);
  assign o_done      = r_state == DONE;
  assign o_pass      = o_done & (r_err == '0);
  assign o_err_count = r_err;
  assign o_fail_idx  = r_fail;
  assign o_captured  = r_cap;
endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper: drives a table-defined fake DUT and checks every sweep against a whole-table reference model.
module tb_truth_table_sweeper;
  localparam logic [7:0] EXP = 8'b10010110;
  logic clk = 0, reset = 1, start = 0;
  logic [7:0] dut_tab = 8'h96;
  logic [2:0] sel, fail;
  logic busy, done, pass;
  logic [3:0] err;
  logic [7:0] cap;
  int errors = 0, checks = 0;

  truth_table_sweeper dut (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_dut_out(dut_tab[sel]),
    .o_sel_abc(sel), .o_busy(busy), .o_done(done), .o_pass(pass),
    .o_err_count(err), .o_fail_idx(fail), .o_captured(cap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go();
    start = 1;
    tick();
    start = 0;
  endtask

  // Called one step after the edge that accepted start; walks the whole sweep.
  task automatic follow(input string tag, input logic [7:0] tab, input bit mid, input bit hold);
    logic [7:0] diff, ecap;
    int nerr, first, stop, len;
    dut_tab = tab;
    diff = tab ^ EXP;
    nerr = $countones(diff);
    first = 0;
    for (int i = 7; i >= 0; i--) if (diff[i]) first = i;
    stop = 7;
    ecap = tab;
`ifdef STOP_ON_FAIL_EN
    if (nerr != 0) begin
      stop = first;
      nerr = 1;
      for (int i = 0; i < 8; i++) if (i > stop) ecap[i] = 1'b0;
    end
`endif
    len = (stop + 1) * 3;
    for (int n = 0; n < len; n++) begin
      chk({tag, " sel"}, 32'(sel), 32'(n / 3));
      chk({tag, " busy"}, 32'(busy), 1);
      chk({tag, " early_done"}, 32'(done), 0);
      start = (mid && n == 10) || (hold && n == len - 1);
      tick();
      if (!(hold && n == len - 1)) start = 0;
    end
    chk({tag, " done"}, 32'(done), 1);
    chk({tag, " busy_done"}, 32'(busy), 0);
    chk({tag, " pass"}, 32'(pass), 32'(nerr == 0));
    chk({tag, " err_count"}, 32'(err), 32'(nerr));
    chk({tag, " fail_idx"}, 32'(fail), 32'(nerr != 0 ? first : 0));
    chk({tag, " captured"}, 32'(cap), 32'(ecap));
    chk({tag, " sel_final"}, 32'(sel), 32'(stop));
    if (hold) begin
      tick();
      start = 0;
      chk({tag, " restart_busy"}, 32'(busy), 1);
      chk({tag, " restart_done"}, 32'(done), 0);
      chk({tag, " restart_cap"}, 32'(cap), 0);
      chk({tag, " restart_err"}, 32'(err), 0);
    end
  endtask

  initial begin
    tick();
    tick();
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_outs", 32'({sel, pass, err, fail, cap}), 0);
    reset = 0;
    tick();
    chk("idle_stays", 32'(busy | done), 0);

    go(); follow("good", 8'h96, 0, 0);
    go(); follow("inverted", 8'h69, 0, 0);
    go(); follow("fault5", 8'hB6, 0, 0);

    go();
    repeat (9) tick();
    chk("abort_sel", 32'(sel), 3);
    reset = 1;
    start = 1;
    tick();
    reset = 0;
    start = 0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_outs", 32'({sel, pass, err, fail, cap}), 0);
    tick();
    chk("abort_idle", 32'(busy | done), 0);
    go(); follow("after_abort", 8'h96, 0, 0);

    go(); follow("mid_and_hold", 8'h69, 1, 1);
    follow("restarted", 8'h96, 0, 0);

    for (int r = 0; r < 6; r++) begin
      go();
      follow($sformatf("rand%0d", r), 8'($urandom), 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
